// File: rtl/gecko_shift_sequencer.sv
// Iterative 32-bit shifter for the gecko execute stage: one power-of-two stride per cycle,
// with valid/ready handshakes on both the command and the result side.
module gecko_shift_sequencer #(
  parameter bit SKIP_ZERO_STEPS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_value,
  input  logic [1:0]  cmd_shift_type,
  input  logic [4:0]  cmd_shift,
  input  logic [4:0]  cmd_reg_addr,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [31:0] result_value,
  output logic [4:0]  result_reg_addr,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [1:0] TYPE_LL = 2'd0;
  localparam logic [1:0] TYPE_RA = 2'd2;

  state_t      r_state, w_nextState;
  logic [31:0] r_value;
  logic [4:0]  r_remaining;
  logic [1:0]  r_type;
  logic        r_sign;
  logic [4:0]  r_tag;
  logic [2:0]  r_step;

  logic        w_accept;
  logic [2:0]  w_msb;
  logic [2:0]  w_k;
  logic        w_doShift;
  logic        w_lastStep;
  logic [4:0]  w_remainingNext;
  logic [31:0] w_stepped;

  // Each stride is a fixed wiring choice, so only a 5:1 mux sits in front of r_value.
  function automatic logic [31:0] strideShift(input logic [31:0] v, input logic [1:0] t,
                                              input logic s, input logic [2:0] k);
    logic [31:0] fill;
    logic        left;
    logic [31:0] res;
    fill = (t == TYPE_RA && s) ? 32'hFFFF_FFFF : 32'h0;
    left = (t == TYPE_LL);
    res  = v;
    case (k)
      3'd4: res = left ? {v[15:0], 16'h0} : {fill[15:0], v[31:16]};
      3'd3: res = left ? {v[23:0], 8'h0}  : {fill[7:0],  v[31:8]};
      3'd2: res = left ? {v[27:0], 4'h0}  : {fill[3:0],  v[31:4]};
      3'd1: res = left ? {v[29:0], 2'h0}  : {fill[1:0],  v[31:2]};
      3'd0: res = left ? {v[30:0], 1'b0}  : {fill[0],    v[31:1]};
      default: res = v;
    endcase
    return res;
  endfunction

  always_comb begin
    w_msb = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (r_remaining[i]) w_msb = 3'(i);
    end
  end

  always_comb begin
    w_k             = r_step;
    w_doShift       = r_remaining[r_step];
    w_lastStep      = (r_step == 3'd0);
    w_remainingNext = r_remaining;
    if (SKIP_ZERO_STEPS) begin
      w_k             = w_msb;
      w_doShift       = 1'b1;
      w_remainingNext = r_remaining & ~(5'd1 << w_msb);
      w_lastStep      = (w_remainingNext == 5'd0);
    end
    w_stepped = strideShift(r_value, r_type, r_sign, w_k);
  end

  assign cmd_ready       = (r_state == IDLE) || (r_state == DONE && result_ready);
  assign w_accept        = cmd_valid && cmd_ready;
  assign result_valid    = (r_state == DONE);
  assign busy            = (r_state != IDLE);
  assign result_value    = r_value;
  assign result_reg_addr = r_tag;

  // A result handshake and a new accept may share the DONE cycle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:  if (w_accept) w_nextState = (SKIP_ZERO_STEPS && cmd_shift == 5'd0) ? DONE : SHIFT;
      SHIFT: if (w_lastStep) w_nextState = DONE;
      DONE: begin
        if (result_ready) begin
          if (w_accept) w_nextState = (SKIP_ZERO_STEPS && cmd_shift == 5'd0) ? DONE : SHIFT;
          else          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_value     <= 32'h0;
      r_remaining <= 5'd0;
      r_type      <= TYPE_LL;
      r_sign      <= 1'b0;
      r_tag       <= 5'd0;
      r_step      <= 3'd0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_value     <= cmd_value;
        r_type      <= (cmd_shift_type == 2'd3) ? TYPE_LL : cmd_shift_type;
        r_sign      <= cmd_value[31];
        r_tag       <= cmd_reg_addr;
        r_remaining <= cmd_shift;
        r_step      <= 3'd4;
      end else if (r_state == SHIFT) begin
        if (w_doShift) r_value <= w_stepped;
        r_remaining <= w_remainingNext;
        r_step      <= r_step - 3'd1;
      end
    end
  end

endmodule
